// File: rtl/operand_fetch_stage_pkg.sv
// Shared operand-fetch definitions: operand source selects (also used by
// ID decode) and the default datapath sizing.
package opfetch_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_NREG   = 8;
   localparam int DEF_CTRL_W = 40;
   localparam int DEF_PC_INC = 2;
   localparam int DEF_CNT_W  = 16;

   typedef enum logic [1:0] {
      A_RA = 2'd0,
      A_RB = 2'd1,
      A_PC = 2'd2
   } src_a_sel_t;

   typedef enum logic [1:0] {
      B_REG   = 2'd0,
      B_IMM   = 2'd1,
      B_CONST = 2'd2
   } src_b_sel_t;

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Instruction bundle entering the stage (ID/RF side) and the registered
// operand bundle leaving it towards EX, each with its own valid/ready pair.
interface operand_fetch_stage_if #(
   parameter int DATA_W = 16,
   parameter int AW     = 3,
   parameter int CTRL_W = 40
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_pc;
   logic [AW-1:0]     in_ra;
   logic [AW-1:0]     in_rb;
   logic              in_use_a;
   logic              in_use_b;
   logic [1:0]        in_srcA_sel;
   logic [1:0]        in_srcB_sel;
   logic [DATA_W-1:0] in_imm;
   logic [CTRL_W-1:0] in_ctrl;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_pc;
   logic [DATA_W-1:0] out_opA;
   logic [DATA_W-1:0] out_opB;
   logic [DATA_W-1:0] out_store_data;
   logic [CTRL_W-1:0] out_ctrl;

   // Driver of instructions into the stage and consumer of its results.
   modport master (
      output in_valid, in_pc, in_ra, in_rb, in_use_a, in_use_b,
             in_srcA_sel, in_srcB_sel, in_imm, in_ctrl, out_ready,
      input  in_ready, out_valid, out_pc, out_opA, out_opB,
             out_store_data, out_ctrl
   );

   // The operand-fetch stage itself.
   modport slave (
      input  in_valid, in_pc, in_ra, in_rb, in_use_a, in_use_b,
             in_srcA_sel, in_srcB_sel, in_imm, in_ctrl, out_ready,
      output in_ready, out_valid, out_pc, out_opA, out_opB,
             out_store_data, out_ctrl
   );
endinterface

// File: rtl/operand_fetch_stage_fwd_mux.sv
// Bypass selection for one source operand: youngest producer wins.
// A load still in EX has no data yet, so it never forwards from EX.
module fwd_mux #(
   parameter int DATA_W = 16,
   parameter int AW     = 3
) (
   input  logic [AW-1:0]     rd_addr,
   input  logic [DATA_W-1:0] rf_data,
   input  logic              ex_wr_en,
   input  logic              ex_is_load,
   input  logic [AW-1:0]     ex_wr_addr,
   input  logic [DATA_W-1:0] ex_wr_data,
   input  logic              mem_wr_en,
   input  logic [AW-1:0]     mem_wr_addr,
   input  logic [DATA_W-1:0] mem_wr_data,
   input  logic              wb_wr_en,
   input  logic [AW-1:0]     wb_wr_addr,
   input  logic [DATA_W-1:0] wb_wr_data,
   output logic [DATA_W-1:0] fwd_data
);

   // Priority EX (non-load) > MEM > WB > register file.
   always_comb begin
      fwd_data = rf_data;
      if (ex_wr_en && !ex_is_load && ex_wr_addr == rd_addr)
         fwd_data = ex_wr_data;
      else if (mem_wr_en && mem_wr_addr == rd_addr)
         fwd_data = mem_wr_data;
      else if (wb_wr_en && wb_wr_addr == rd_addr)
         fwd_data = wb_wr_data;
   end

endmodule

// File: rtl/operand_fetch_stage.sv
// Registered operand-fetch stage: RF read, EX/MEM/WB forwarding, operand
// selection, load-use stall and a valid/ready output register towards EX.
module operand_fetch_stage
   import opfetch_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int NREG   = DEF_NREG,
   parameter int CTRL_W = DEF_CTRL_W,
   parameter int PC_INC = DEF_PC_INC,
   parameter int CNT_W  = DEF_CNT_W,
   parameter int AW     = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   operand_fetch_stage_if.slave bus,
   output logic [AW-1:0]     rf_raddr_a,
   output logic [AW-1:0]     rf_raddr_b,
   input  logic [DATA_W-1:0] rf_rdata_a,
   input  logic [DATA_W-1:0] rf_rdata_b,
   input  logic              ex_wr_en,
   input  logic [AW-1:0]     ex_wr_addr,
   input  logic [DATA_W-1:0] ex_wr_data,
   input  logic              ex_is_load,
   input  logic              mem_wr_en,
   input  logic [AW-1:0]     mem_wr_addr,
   input  logic [DATA_W-1:0] mem_wr_data,
   input  logic              wb_wr_en,
   input  logic [AW-1:0]     wb_wr_addr,
   input  logic [DATA_W-1:0] wb_wr_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic [DATA_W-1:0] rf_rdata [2];
   logic [AW-1:0]     src_addr [2];
   logic [DATA_W-1:0] fwd      [2];

   logic              out_valid_reg;
   logic [DATA_W-1:0] out_pc_reg, out_opa_reg, out_opb_reg, out_store_reg;
   logic [CTRL_W-1:0] out_ctrl_reg;
   logic [CNT_W-1:0]  stall_cnt_reg;

   logic              hazard, adv, load_en;
   logic [DATA_W-1:0] opa_next, opb_next;

   assign src_addr[0] = bus.in_ra;
   assign src_addr[1] = bus.in_rb;
   assign rf_rdata[0] = rf_rdata_a;
   assign rf_rdata[1] = rf_rdata_b;
   assign rf_raddr_a  = bus.in_ra;
   assign rf_raddr_b  = bus.in_rb;

   // One bypass mux per source register.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
         fwd_mux #(.DATA_W(DATA_W), .AW(AW)) u_fwd_mux (
            .rd_addr     (src_addr[gi]),
            .rf_data     (rf_rdata[gi]),
            .ex_wr_en    (ex_wr_en),
            .ex_is_load  (ex_is_load),
            .ex_wr_addr  (ex_wr_addr),
            .ex_wr_data  (ex_wr_data),
            .mem_wr_en   (mem_wr_en),
            .mem_wr_addr (mem_wr_addr),
            .mem_wr_data (mem_wr_data),
            .wb_wr_en    (wb_wr_en),
            .wb_wr_addr  (wb_wr_addr),
            .wb_wr_data  (wb_wr_data),
            .fwd_data    (fwd[gi])
         );
      end
   endgenerate

   // Load-use hazard only counts for sources the instruction really reads.
   assign hazard = bus.in_valid && ex_wr_en && ex_is_load &&
                   ((bus.in_use_a && ex_wr_addr == bus.in_ra) ||
                    (bus.in_use_b && ex_wr_addr == bus.in_rb));
   assign adv          = !out_valid_reg || bus.out_ready;
   assign bus.in_ready = rst_n && !flush && adv && !hazard;
   assign load_en      = adv && bus.in_valid && !hazard;

   // Operand selection; unused encodings yield zero.
   always_comb begin
      opa_next = '0;
      opb_next = '0;
      case (bus.in_srcA_sel)
         A_RA:    opa_next = fwd[0];
         A_RB:    opa_next = fwd[1];
         A_PC:    opa_next = bus.in_pc;
         default: opa_next = '0;
      endcase
      case (bus.in_srcB_sel)
         B_REG:   opb_next = fwd[1];
         B_IMM:   opb_next = bus.in_imm;
         B_CONST: opb_next = DATA_W'(PC_INC);
         default: opb_next = '0;
      endcase
   end

   // Output register: flush kills, accept loads, idle drains, backpressure holds.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
         out_pc_reg    <= '0;
         out_opa_reg   <= '0;
         out_opb_reg   <= '0;
         out_store_reg <= '0;
         out_ctrl_reg  <= '0;
      end else if (flush) begin
         out_valid_reg <= 1'b0;
      end else if (load_en) begin
         out_valid_reg <= 1'b1;
         out_pc_reg    <= bus.in_pc;
         out_opa_reg   <= opa_next;
         out_opb_reg   <= opb_next;
         out_store_reg <= fwd[0];
         out_ctrl_reg  <= bus.in_ctrl;
      end else if (adv) begin
         out_valid_reg <= 1'b0;
      end
   end

   // Saturating count of cycles lost to load-use stalls.
   always_ff @(posedge clk) begin
      if (!rst_n)
         stall_cnt_reg <= '0;
      else if (hazard && adv && !flush && stall_cnt_reg != '1)
         stall_cnt_reg <= stall_cnt_reg + 1'b1;
   end

   assign bus.out_valid      = out_valid_reg;
   assign bus.out_pc         = out_pc_reg;
   assign bus.out_opA        = out_opa_reg;
   assign bus.out_opB        = out_opb_reg;
   assign bus.out_store_data = out_store_reg;
   assign bus.out_ctrl       = out_ctrl_reg;
   assign stall_cnt          = stall_cnt_reg;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: reset, forwarding priority,
// load-use stall, backpressure, flush and operand selection.
module tb_operand_fetch_stage;
   import opfetch_pkg::*;

   localparam int DATA_W = 16;
   localparam int NREG   = 8;
   localparam int CTRL_W = 40;
   localparam int CNT_W  = 16;
   localparam int AW     = 3;

   logic              clk = 1'b0;
   logic              rst_n, flush;
   logic [AW-1:0]     rf_raddr_a, rf_raddr_b;
   logic [DATA_W-1:0] rf_rdata_a, rf_rdata_b;
   logic              ex_wr_en, ex_is_load, mem_wr_en, wb_wr_en;
   logic [AW-1:0]     ex_wr_addr, mem_wr_addr, wb_wr_addr;
   logic [DATA_W-1:0] ex_wr_data, mem_wr_data, wb_wr_data;
   logic [CNT_W-1:0]  stall_cnt;

   int tests_run = 0;
   int tests_failed = 0;

   operand_fetch_stage_if #(.DATA_W(DATA_W), .AW(AW), .CTRL_W(CTRL_W)) bus ();

   operand_fetch_stage #(
      .DATA_W(DATA_W), .NREG(NREG), .CTRL_W(CTRL_W), .PC_INC(2), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus),
      .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
      .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
      .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data),
      .ex_is_load(ex_is_load),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0;
      rf_rdata_a = '0; rf_rdata_b = '0;
      ex_wr_en = 0; ex_is_load = 0; ex_wr_addr = '0; ex_wr_data = '0;
      mem_wr_en = 0; mem_wr_addr = '0; mem_wr_data = '0;
      wb_wr_en = 0; wb_wr_addr = '0; wb_wr_data = '0;
      bus.in_valid = 1'b1; bus.in_pc = '0; bus.in_ra = '0; bus.in_rb = '0;
      bus.in_use_a = 0; bus.in_use_b = 0;
      bus.in_srcA_sel = A_RA; bus.in_srcB_sel = B_REG;
      bus.in_imm = '0; bus.in_ctrl = '0; bus.out_ready = 1'b1;

      // Reset held for two cycles with a valid instruction waiting.
      tick(); tick();
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
      chk("rst_opA", 64'(bus.out_opA), 64'd0);
      chk("rst_ctrl", 64'(bus.out_ctrl), 64'd0);

      // Forwarding priority on ra=3: EX > MEM > WB > RF.
      rst_n = 1'b1;
      bus.in_ra = 3; bus.in_use_a = 1; bus.in_srcA_sel = A_RA;
      bus.in_srcB_sel = B_IMM; bus.in_imm = 16'h00AA;
      bus.in_pc = 16'h0010; bus.in_ctrl = 40'hAB_CDEF_0123;
      rf_rdata_a = 16'h0BAD;
      ex_wr_en = 1; ex_wr_addr = 3; ex_wr_data = 16'h1111;
      mem_wr_en = 1; mem_wr_addr = 3; mem_wr_data = 16'h2222;
      wb_wr_en = 1; wb_wr_addr = 3; wb_wr_data = 16'h3333;
      #1;
      chk("fwd_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rf_raddr_a", 64'(rf_raddr_a), 64'd3);
      tick();
      chk("fwd_out_valid", 64'(bus.out_valid), 64'd1);
      chk("fwd_ex_opA", 64'(bus.out_opA), 64'h1111);
      chk("fwd_imm_opB", 64'(bus.out_opB), 64'h00AA);
      chk("fwd_store", 64'(bus.out_store_data), 64'h1111);
      chk("fwd_pc", 64'(bus.out_pc), 64'h0010);
      chk("fwd_ctrl", 64'(bus.out_ctrl), 64'hAB_CDEF_0123);
      ex_wr_en = 0;
      tick();
      chk("fwd_mem_over_wb", 64'(bus.out_opA), 64'h2222);
      mem_wr_en = 0;
      tick();
      chk("fwd_wb", 64'(bus.out_opA), 64'h3333);
      wb_wr_en = 0;
      tick();
      chk("fwd_rf", 64'(bus.out_opA), 64'h0BAD);

      // Load-use: EX loads r5, instruction reads rb=5.
      bus.in_ra = 1; bus.in_rb = 5; bus.in_srcB_sel = B_REG;
      rf_rdata_a = 16'h0101; rf_rdata_b = 16'h0BBB;
      ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 5; ex_wr_data = 16'hDEAD;
      bus.in_use_b = 0;
      #1;
      chk("lu_unused_b_ready", 64'(bus.in_ready), 64'd1);
      bus.in_use_b = 1;
      #1;
      chk("lu_in_ready", 64'(bus.in_ready), 64'd0);
      tick();
      chk("lu_bubble", 64'(bus.out_valid), 64'd0);
      chk("lu_stall_cnt", 64'(stall_cnt), 64'd1);
      ex_wr_en = 0; ex_is_load = 0;
      mem_wr_en = 1; mem_wr_addr = 5; mem_wr_data = 16'h5555;
      #1;
      chk("lu_release_ready", 64'(bus.in_ready), 64'd1);
      tick();
      chk("lu_out_valid", 64'(bus.out_valid), 64'd1);
      chk("lu_opB_mem", 64'(bus.out_opB), 64'h5555);
      chk("lu_cnt_hold", 64'(stall_cnt), 64'd1);
      mem_wr_en = 0;

      // Backpressure for 4 cycles, then release; new instr uses PC/CONST.
      bus.out_ready = 0;
      bus.in_pc = 16'h0040; bus.in_srcA_sel = A_PC; bus.in_srcB_sel = B_CONST;
      wb_wr_en = 1; wb_wr_addr = 1; wb_wr_data = 16'h7777;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("bp_valid", 64'(bus.out_valid), 64'd1);
         chk("bp_opB_stable", 64'(bus.out_opB), 64'h5555);
         chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      end
      bus.out_ready = 1;
      #1;
      chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
      tick();
      chk("mux_pc", 64'(bus.out_pc), 64'h0040);
      chk("mux_opA_pc", 64'(bus.out_opA), 64'h0040);
      chk("mux_opB_const", 64'(bus.out_opB), 64'h0002);
      chk("mux_store_fwd", 64'(bus.out_store_data), 64'h7777);
      wb_wr_en = 0;

      // Flush coinciding with a load-use hazard.
      ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 5;
      flush = 1;
      #1;
      chk("fl_in_ready", 64'(bus.in_ready), 64'd0);
      tick();
      chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
      chk("fl_cnt_unchanged", 64'(stall_cnt), 64'd1);
      flush = 0; ex_wr_en = 0; ex_is_load = 0;

      // Unused select encodings give zero operands.
      bus.in_srcA_sel = 2'd3; bus.in_srcB_sel = 2'd3;
      tick();
      chk("mux_opA_zero", 64'(bus.out_opA), 64'd0);
      chk("mux_opB_zero", 64'(bus.out_opB), 64'd0);

      // Reset during backpressure clears everything.
      bus.out_ready = 0;
      tick();
      rst_n = 0;
      tick();
      chk("rst_mid_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_mid_cnt", 64'(stall_cnt), 64'd0);
      chk("rst_mid_in_ready", 64'(bus.in_ready), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
